serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell, used as the per-bit adder of serial_adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    // Sum and carry of three input bits
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, around a single full_adder.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow output OVF.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic w_sum;
    logic w_cout;

    // Per-bit adder cell fed from the operand LSBs and the running carry
    full_adder u_fa (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_carry),
        .S    (w_sum),
        .Cout (w_cout)
    );

    // Control FSM, counter and shift registers with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh   <= A;
                        r_b_sh   <= B;
                        r_carry  <= Cin;
                        r_sum_sh <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum_sh <= {w_sum, r_sum_sh[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_count  <= r_count + CW'(1);
                    // Last bit: capture the final carry and hand off to DONE
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_cout  <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf   <= r_carry ^ w_cout;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign S    = r_sum_sh;
    assign Cout = r_cout;
    assign busy = r_busy;
    assign done = r_done;
`ifdef SERIAL_ADDER_OVF_EN
    assign OVF  = r_ovf;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder with randomized operands and an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [WIDTH-1:0] s_out;
    logic             cout_out;
    logic             busy;
    logic             done;
    logic             ovf;

    int unsigned checks;
    int unsigned failures;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Cin   (cin_in),
        .S     (s_out),
        .Cout  (cout_out),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF   (ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full unsigned sum with carry kept
    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin);
        return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
    endfunction

    // Reference: two's-complement overflow from operand/result signs
    function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin);
        logic [WIDTH:0] t;
        t = ref_sum(a, b, cin);
        return (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Issue one add, wait (bounded) for done, return result and timing; leaves DUT in IDLE
    task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                           output logic [WIDTH-1:0] s_o, output logic c_o, output logic v_o,
                           output int lat, output int bcnt, output bit got);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = cin;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a_in   = WIDTH'($urandom);
        b_in   = WIDTH'($urandom);
        cin_in = 1'($urandom);
        lat  = 0;
        bcnt = 0;
        got  = 1'b0;
        for (int i = 0; i < 4 * int'(WIDTH); i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(posedge clk);
            lat++;
        end
        s_o = s_out;
        c_o = cout_out;
        v_o = ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({s_out, cout_out, busy, done, ovf} !== '0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d S=%h Cout=%b busy=%b done=%b ovf=%b required all 0",
                         i, s_out, cout_out, busy, done, ovf);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] s;
        logic c, v;
        int lat, bcnt;
        bit got;
        run_add(8'h0F, 8'h01, 1'b0, s, c, v, lat, bcnt, got);
        checks++;
        if (got !== 1'b1) begin failures++; $display("FAIL basic_done_seen got=%b required 1", got); end
        checks++;
        if (lat != int'(WIDTH)) begin failures++; $display("FAIL basic_latency got=%0d required %0d", lat, WIDTH); end
        checks++;
        if (bcnt != int'(WIDTH)) begin failures++; $display("FAIL basic_busy_cycles got=%0d required %0d", bcnt, WIDTH); end
        checks++;
        if ({c, s} !== 9'h010) begin failures++; $display("FAIL basic_sum got=%b_%h required 0_10", c, s); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_directed_hold();
        logic [WIDTH-1:0] s;
        logic c, v;
        int lat, bcnt;
        bit got;
        run_add(8'hFF, 8'h01, 1'b0, s, c, v, lat, bcnt, got);
        checks++;
        if (got !== 1'b1 || {c, s} !== 9'h100) begin
            failures++;
            $display("FAIL ff_plus_01 got=%b_%h done_seen=%b required 1_00", c, s, got);
        end
        run_add(8'hAA, 8'h55, 1'b1, s, c, v, lat, bcnt, got);
        checks++;
        if (got !== 1'b1 || {c, s} !== 9'h100) begin
            failures++;
            $display("FAIL aa_plus_55_c1 got=%b_%h done_seen=%b required 1_00", c, s, got);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({cout_out, s_out} !== 9'h100 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d got=%b_%h busy=%b done=%b required 1_00 0 0",
                         i, cout_out, s_out, busy, done);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_during_run();
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0] exp;
        int ndone, nbusy;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        exp = ref_sum(a, b, 1'b0);
        start = 1'b1; a_in = a; b_in = b; cin_in = 1'b0;
        @(posedge clk);
        #1;
        a_in = ~a; b_in = ~b; cin_in = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4 * int'(WIDTH); i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                start = 1'b0;
                checks++;
                if ({cout_out, s_out} !== exp) begin
                    failures++;
                    $display("FAIL restart_ignored_sum got=%b_%h required %b_%h", cout_out, s_out,
                             exp[WIDTH], exp[WIDTH-1:0]);
                end
                break;
            end
        end
        start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 2 * int'(WIDTH); i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        checks++;
        if (ndone != 1 || nbusy != 0) begin
            failures++;
            $display("FAIL restart_single_done done_pulses=%0d later_busy=%0d required 1 0", ndone, nbusy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] s;
        logic c, v;
        int lat, bcnt, ndone;
        bit got;
        start = 1'b1; a_in = 8'hA5; b_in = 8'h3C; cin_in = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_out, cout_out, busy, done} !== '0) begin
            failures++;
            $display("FAIL midrun_reset S=%h Cout=%b busy=%b done=%b required 0 0 0 0",
                     s_out, cout_out, busy, done);
        end
        ndone = 0;
        for (int i = 0; i < 2 * int'(WIDTH); i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin failures++; $display("FAIL midrun_no_done activity=%0d required 0", ndone); end
        @(posedge clk);
        #1;
        run_add(8'h12, 8'h34, 1'b0, s, c, v, lat, bcnt, got);
        checks++;
        if (got !== 1'b1 || {c, s} !== 9'h046) begin
            failures++;
            $display("FAIL post_reset_add got=%b_%h done_seen=%b required 0_46", c, s, got);
        end
    endtask

    task automatic test_rst_and_start();
        int act;
        start = 1'b1; rst = 1'b1; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0;
        @(posedge clk);
        #1 start = 1'b0; rst = 1'b0;
        act = 0;
        for (int i = 0; i < int'(WIDTH) + 3; i++) begin
            @(negedge clk);
            if (busy || done) act++;
        end
        checks++;
        if (act != 0) begin failures++; $display("FAIL rst_beats_start activity=%0d required 0", act); end
        @(posedge clk);
        #1;
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [WIDTH-1:0] s;
        logic c, v;
        int lat, bcnt;
        bit got;
        run_add(8'h7F, 8'h01, 1'b0, s, c, v, lat, bcnt, got);
        checks++;
        if ({v, c, s} !== 10'b1_0_1000_0000) begin
            failures++; $display("FAIL ovf_7f_01 got ovf=%b %b_%h required 1 0_80", v, c, s);
        end
        run_add(8'h80, 8'h80, 1'b0, s, c, v, lat, bcnt, got);
        checks++;
        if ({v, c, s} !== 10'b1_1_0000_0000) begin
            failures++; $display("FAIL ovf_80_80 got ovf=%b %b_%h required 1 1_00", v, c, s);
        end
        run_add(8'hFF, 8'h01, 1'b0, s, c, v, lat, bcnt, got);
        checks++;
        if (v !== 1'b0) begin failures++; $display("FAIL ovf_ff_01 got ovf=%b required 0", v); end
    endtask
`endif

    task automatic test_random(input int n);
        logic [WIDTH-1:0] a, b, s;
        logic cin, c, v, ev;
        logic [WIDTH:0] exp;
        int lat, bcnt;
        bit got;
        for (int i = 0; i < n; i++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
            exp = ref_sum(a, b, cin);
`ifdef SERIAL_ADDER_OVF_EN
            ev  = ref_ovf(a, b, cin);
`else
            ev  = 1'b0;
`endif
            run_add(a, b, cin, s, c, v, lat, bcnt, got);
            checks++;
            if (got !== 1'b1 || {c, s} !== exp || v !== ev || lat != int'(WIDTH)) begin
                failures++;
                $display("FAIL random_add #%0d %h+%h+%b got=%b_%h ovf=%b lat=%0d required %b_%h ovf=%b lat=%0d",
                         i, a, b, cin, c, s, v, lat, exp[WIDTH], exp[WIDTH-1:0], ev, WIDTH);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        cin_in   = 1'b0;
        test_reset();
        test_basic();
        test_directed_hold();
        test_start_during_run();
        test_reset_mid_run();
        test_rst_and_start();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
        test_random(1000);
`else
        test_random(300);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_adder
